// File: rtl/fp_fma_sched.sv
// Round-robin scheduler that shares one fixed-latency, non-stallable FMA among
// NREQ requesters. Issue is credit-gated, and a tag pipe steers each result to its owner's FIFO.

module fp_fma_sched_lane #(
  parameter int RES_W = 128,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             grant_i,
  input  logic             push_i,
  input  logic [RES_W-1:0] push_data_i,
  input  logic             pop_i,
  output logic             has_credit_o,
  output logic             res_valid_o,
  output logic [RES_W-1:0] res_data_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]              credit_q, credit_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0][RES_W-1:0] mem_q;
  logic                       pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop          = pop_i && (cnt_q != '0);
  assign has_credit_o = (credit_q != '0);
  assign res_valid_o  = (cnt_q != '0);
  assign res_data_o   = mem_q[rd_ptr_q];

  // Credits cover in-flight ops plus FIFO occupancy, so a push always finds room.
  always_comb begin
    credit_d = credit_q;
    if (grant_i && !pop)      credit_d = credit_q - CW'(1);
    else if (!grant_i && pop) credit_d = credit_q + CW'(1);
  end

  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_i && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push_i && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      credit_q <= CW'(DEPTH);
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

module fp_fma_sched #(
  parameter int NREQ  = 4,
  parameter int REQ_W = 256,
  parameter int RES_W = 128,
  parameter int LAT   = 5,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][REQ_W-1:0] req_data,
  output logic                       fma_valid,
  output logic [REQ_W-1:0]           fma_data,
  input  logic                       fma_res_valid,
  input  logic [RES_W-1:0]           fma_res_data,
  output logic [NREQ-1:0]            res_valid,
  input  logic [NREQ-1:0]            res_ready,
  output logic [NREQ-1:0][RES_W-1:0] res_data,
  output logic                       busy,
  output logic                       err
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]          has_credit, elig, push;
  logic [IDW-1:0]           rr_q, rr_d, gidx, cand;
  logic                     gvld;
  int                       idx;
  logic [LAT:0]             vld_pipe_q;
  logic [LAT:0][IDW-1:0]    id_pipe_q;
  logic [REQ_W-1:0]         fma_data_q;
  logic                     err_q;

  assign elig = req_valid & has_credit & {NREQ{reset}};

  always_comb begin
    gvld = 1'b0;
    gidx = '0;
    idx  = 0;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx  = (int'(rr_q) + k) % NREQ;
      cand = IDW'(idx);
      if (!gvld && elig[cand]) begin
        gvld = 1'b1;
        gidx = cand;
      end
    end
  end

  assign req_ready = gvld ? (NREQ'(1) << gidx) : '0;
  assign rr_d      = !gvld ? rr_q : ((int'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1));

  // Stage 0 is the issue register (drives fma_valid); stage LAT lines up with fma_res_valid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_q       <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      fma_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      vld_pipe_q <= {vld_pipe_q[LAT-1:0], gvld};
      id_pipe_q  <= {id_pipe_q[LAT-1:0], gidx};
      fma_data_q <= gvld ? req_data[gidx] : '0;
      err_q      <= err_q | (fma_res_valid ^ vld_pipe_q[LAT]);
    end
  end

  assign fma_valid = vld_pipe_q[0];
  assign fma_data  = fma_data_q;
  assign err       = err_q;
  assign busy      = (|vld_pipe_q) | (|res_valid);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    // A result without a matching tag (or vice versa) is dropped and flagged.
    assign push[i] = fma_res_valid && vld_pipe_q[LAT] && (id_pipe_q[LAT] == IDW'(i));

    fp_fma_sched_lane #(
      .RES_W (RES_W),
      .DEPTH (DEPTH)
    ) u_lane (
      .clock        (clock),
      .reset        (reset),
      .grant_i      (req_ready[i]),
      .push_i       (push[i]),
      .push_data_i  (fma_res_data),
      .pop_i        (res_ready[i]),
      .has_credit_o (has_credit[i]),
      .res_valid_o  (res_valid[i]),
      .res_data_o   (res_data[i])
    );
  end
endmodule

// File: tb/tb_fp_fma_sched.sv
// Bench for fp_fma_sched: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_fp_fma_sched;
  localparam int NREQ  = 4;
  localparam int REQ_W = 256;
  localparam int RES_W = 128;
  localparam int LAT   = 5;
  localparam int DEPTH = 2;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][REQ_W-1:0] req_data;
  logic                       fma_valid;
  logic [REQ_W-1:0]           fma_data;
  logic                       fma_res_valid;
  logic [RES_W-1:0]           fma_res_data;
  logic [NREQ-1:0]            res_valid;
  logic [NREQ-1:0]            res_ready;
  logic [NREQ-1:0][RES_W-1:0] res_data;
  logic                       busy;
  logic                       err;
  logic                       spur;

  int ncheck = 0;
  int nerr   = 0;

  always #5 clock = ~clock;

  fp_fma_sched #(
    .NREQ (NREQ), .REQ_W (REQ_W), .RES_W (RES_W), .LAT (LAT), .DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .fma_valid     (fma_valid),
    .fma_data      (fma_data),
    .fma_res_valid (fma_res_valid),
    .fma_res_data  (fma_res_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .busy          (busy),
    .err           (err)
  );

  function automatic logic [RES_W-1:0] fma_fn(input logic [REQ_W-1:0] d);
    return d[RES_W-1:0] + d[2*RES_W-1:RES_W];
  endfunction

  // FMA stand-in: LAT-cycle delay from fma_valid to fma_res_valid, shared reset.
  logic [LAT-1:0]   p_vld;
  logic [REQ_W-1:0] p_dat [LAT];
  always @(posedge clock) begin
    if (!reset) p_vld <= '0;
    else begin
      p_vld    <= {p_vld[LAT-2:0], fma_valid};
      p_dat[0] <= fma_data;
      for (int k = 1; k < LAT; k++) p_dat[k] <= p_dat[k-1];
    end
  end
  assign fma_res_valid = p_vld[LAT-1] | spur;
  assign fma_res_data  = fma_fn(p_dat[LAT-1]);

  task automatic chk(input string nm, input logic [REQ_W-1:0] a, input logic [REQ_W-1:0] e);
    ncheck++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  // Reference model: in-flight list with due edge, result queues per requester.
  typedef struct { int id; logic [REQ_W-1:0] d; int due; } fl_t;
  fl_t              infl[$];
  logic [RES_W-1:0] rq [NREQ][$];
  int               rr_m    = 0;
  int               ecnt    = 0;
  bit               started = 0;
  logic             exp_fv  = 1'b0;
  logic [REQ_W-1:0] exp_fd  = '0;
  logic             exp_err = 1'b0;

  function automatic int credit_m(input int r);
    int n;
    n = 0;
    foreach (infl[k]) if (infl[k].id == r) n++;
    return DEPTH - n - rq[r].size();
  endfunction

  always @(negedge clock) begin
    int g, i;
    bit due;
    logic [NREQ-1:0] er, ev, popm;
    g = -1; er = '0; ev = '0; popm = '0; i = 0; due = 0;
    if (reset === 1'b1)
      for (int k = 0; k < NREQ; k++) begin
        i = (rr_m + k) % NREQ;
        if (g < 0 && req_valid[i] && credit_m(i) > 0) g = i;
      end
    if (g >= 0) er[g] = 1'b1;
    for (int k = 0; k < NREQ; k++) ev[k] = (rq[k].size() > 0);
    if (started) begin
      chk("m_req_ready", REQ_W'(req_ready), REQ_W'(er));
      chk("m_fma_valid", REQ_W'(fma_valid), REQ_W'(exp_fv));
      chk("m_fma_data", fma_data, exp_fd);
      chk("m_res_valid", REQ_W'(res_valid), REQ_W'(ev));
      for (int k = 0; k < NREQ; k++)
        if (ev[k]) chk("m_res_data", REQ_W'(res_data[k]), REQ_W'(rq[k][0]));
      chk("m_busy", REQ_W'(busy), REQ_W'(infl.size() > 0 || ev != '0));
      chk("m_err", REQ_W'(err), REQ_W'(exp_err));
    end
    if (reset !== 1'b1) begin
      infl.delete();
      for (int k = 0; k < NREQ; k++) rq[k].delete();
      rr_m = 0; exp_fv = 1'b0; exp_fd = '0; exp_err = 1'b0; started = 1;
    end else begin
      for (int k = 0; k < NREQ; k++) popm[k] = res_ready[k] && ev[k];
      for (int k = 0; k < NREQ; k++) if (popm[k]) void'(rq[k].pop_front());
      while (infl.size() > 0 && infl[0].due <= ecnt) begin
        rq[infl[0].id].push_back(fma_fn(infl[0].d));
        void'(infl.pop_front());
        due = 1;
      end
      if (spur && !due) exp_err = 1'b1;
      if (g >= 0) begin
        infl.push_back('{g, req_data[g], ecnt + LAT + 1});
        rr_m = (g + 1) % NREQ;
      end
      exp_fv = (g >= 0);
      exp_fd = (g >= 0) ? req_data[g] : '0;
    end
    ecnt++;
  end

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    res_ready = '1;
    repeat (n) nxt();
  endtask

  initial begin
    int n, cnt, cnt_o, prev, g, gg, pp;
    bit ok;
    reset = 1'b0; req_valid = '0; res_ready = '0; req_data = '0; spur = 1'b0;
    repeat (2) nxt();
    reset = 1'b1;
    #1;
    chk("rst_busy", REQ_W'(busy), '0);
    chk("rst_res_valid", REQ_W'(res_valid), '0);
    chk("rst_fma_valid", REQ_W'(fma_valid), '0);

    // Single op from requester 0
    nxt();
    req_data[0] = {32{8'hA5}};
    req_valid   = 4'b0001;
    #1;
    chk("t1_ready", REQ_W'(req_ready), REQ_W'(4'b0001));
    nxt();
    req_valid = '0;
    chk("t1_fma_valid", REQ_W'(fma_valid), REQ_W'(1'b1));
    chk("t1_fma_data", fma_data, {32{8'hA5}});
    n = 1;
    while (!res_valid[0] && n < 20) begin nxt(); n++; end
    chk("t1_latency", REQ_W'(n), REQ_W'(7));
    chk("t1_res", REQ_W'(res_data[0]), REQ_W'({{15{8'h4B}}, 8'h4A}));
    res_ready = 4'b0001;
    nxt();
    res_ready = '0;
    #1;
    chk("t1_popped", REQ_W'(res_valid[0]), '0);
    req_valid = 4'b0001;
    cnt = 0;
    repeat (6) begin #1; cnt += int'(req_ready[0]); nxt(); end
    chk("t1_credit2", REQ_W'(cnt), REQ_W'(2));
    idle(14);

    // Round-robin with all requesters active
    req_valid = 4'b1111; res_ready = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_data[i] = {8{32'(i + 32'h100)}};
    prev = -1; ok = 1;
    repeat (16) begin
      #1;
      g = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
      if (g < 0 || $countones(req_ready) != 1) ok = 0;
      if (prev >= 0 && g != (prev + 1) % NREQ) ok = 0;
      prev = g;
      nxt();
    end
    chk("t2_rr_seq", REQ_W'(ok), REQ_W'(1));
    idle(14);

    // Credit stall on requester 2
    req_valid = 4'b1111; res_ready = 4'b1011;
    cnt = 0; cnt_o = 0;
    repeat (20) begin
      #1;
      cnt   += int'(req_ready[2]);
      cnt_o += int'(req_ready[0]) + int'(req_ready[1]) + int'(req_ready[3]);
      nxt();
    end
    chk("t3_g2", REQ_W'(cnt), REQ_W'(2));
    chk("t3_others", REQ_W'(cnt_o >= 10), REQ_W'(1));
    req_valid = 4'b0100; res_ready = 4'b1111;
    #1;
    chk("t3_still_blocked", REQ_W'(req_ready[2]), '0);
    nxt();
    res_ready = 4'b1011;
    #1;
    chk("t3_reopen", REQ_W'(req_ready[2]), REQ_W'(1));
    nxt();
    idle(14);

    // Single requester streaming with immediate pops: grant and pop coincide
    req_valid = 4'b0010; res_ready = 4'b0010;
    gg = 0; pp = 0;
    repeat (40) begin
      #1;
      gg += int'(req_ready[1]);
      pp += int'(res_valid[1] & res_ready[1]);
      nxt();
    end
    req_valid = '0;
    repeat (12) begin #1; pp += int'(res_valid[1] & res_ready[1]); nxt(); end
    chk("t4_noloss", REQ_W'(pp), REQ_W'(gg));
    chk("t4_rate", REQ_W'(gg >= 10), REQ_W'(1));
    idle(4);

    // Reset with ops in flight
    req_valid = 4'b0111; res_ready = '0;
    repeat (3) nxt();
    reset = 1'b0; req_valid = 4'b1111;
    #1;
    chk("t5_no_grant_in_reset", REQ_W'(req_ready), '0);
    nxt();
    reset = 1'b1; req_valid = 4'b1000;
    #1;
    chk("t5_busy", REQ_W'(busy), '0);
    chk("t5_res_valid", REQ_W'(res_valid), '0);
    chk("t5_first_grant", REQ_W'(req_ready), REQ_W'(4'b1000));
    nxt();
    idle(14);

    // Spurious FMA result
    spur = 1'b1;
    nxt();
    spur = 1'b0;
    #1;
    chk("t6_err", REQ_W'(err), REQ_W'(1));
    chk("t6_no_push", REQ_W'(res_valid), '0);
    repeat (5) nxt();
    chk("t6_err_sticky", REQ_W'(err), REQ_W'(1));
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    #1;
    chk("t6_err_clr", REQ_W'(err), '0);

    // Random traffic
    repeat (600) begin
      req_valid = NREQ'($urandom);
      res_ready = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        for (int w = 0; w < REQ_W / 32; w++) req_data[i][w*32 +: 32] = $urandom;
      reset = ($urandom_range(0, 99) != 0);
      nxt();
    end
    reset = 1'b1;
    idle(16);

    $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
    $finish;
  end
endmodule
